// File: rtl/div_pkg.sv
// Shared opcode/state encodings and opcode classification helpers for the
// iterative RV32M divide stage.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_signed(div_op_t op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic is_rem(div_op_t op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor from the XLEN+1 bit partial remainder, commit when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    assign shifted = {rem, quo[XLEN-1]};
    assign fits    = shifted >= {1'b0, divisor};
    // When the subtraction fits, the true difference is below the divisor,
    // so the low XLEN bits of the modular difference are exact.
    assign diff    = shifted[XLEN-1:0] - divisor;

    assign rem_next = fits ? diff : shifted[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/iter_div_stage.sv
// Multi-cycle DIV/DIVU/REM/REMU execute stage; stalls upstream while busy and
// hands its registered result to writeback with a valid/stall handshake.
module iter_div_stage
    import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  div_op_t          op_in,
    input  logic [XLEN-1:0]  a_in,
    input  logic [XLEN-1:0]  b_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             input_valid,
    output logic             stall_out,
    output logic [XLEN-1:0]  result_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             valid_out,
    input  logic             stall_in
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state, state_next;
    logic [CW-1:0]    cnt;
    div_op_t          op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  rem_q, quo_q, dvsr_q, result_q;
    logic             neg_quo_q, neg_rem_q;

    logic             accept, a_neg, b_neg, div_zero, ovf, special;
    logic [XLEN-1:0]  a_abs, b_abs, special_res;
    logic [XLEN-1:0]  step_rem, step_quo, fix_quo, fix_rem, final_res;

    // Operand classification for the op being offered this cycle.
    assign accept      = (state == DIV_IDLE) && input_valid && !flush;
    assign a_neg       = is_signed(op_in) && a_in[XLEN-1];
    assign b_neg       = is_signed(op_in) && b_in[XLEN-1];
    assign a_abs       = a_neg ? -a_in : a_in;
    assign b_abs       = b_neg ? -b_in : b_in;
    assign div_zero    = (b_in == '0);
    assign ovf         = is_signed(op_in) && (a_in == MIN_NEG) && (b_in == '1);
    assign special     = div_zero || ovf;
    assign special_res = div_zero ? (is_rem(op_in) ? a_in : '1)
                                  : (is_rem(op_in) ? '0   : a_in);

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fixups are applied to the final step's output so DONE holds the answer.
    assign fix_quo   = neg_quo_q ? -step_quo : step_quo;
    assign fix_rem   = neg_rem_q ? -step_rem : step_rem;
    assign final_res = is_rem(op_q) ? fix_rem : fix_quo;

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (accept) state_next = special ? DIV_DONE : DIV_CALC;
            DIV_CALC: begin
                if (flush)           state_next = DIV_IDLE;
                else if (cnt == '0)  state_next = DIV_DONE;
            end
            DIV_DONE: if (flush || !stall_in) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            op_q      <= DIV_OP_DIV;
            tag_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q  <= op_in;
                tag_q <= tag_in;
                if (special) begin
                    result_q <= special_res;
                end else begin
                    rem_q     <= '0;
                    quo_q     <= a_abs;
                    dvsr_q    <= b_abs;
                    cnt       <= CW'(XLEN - 1);
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                end
            end else if (state == DIV_CALC && !flush) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                if (cnt == '0) result_q <= final_res;
                else           cnt      <= cnt - 1'b1;
            end
        end
    end

    // stall_out must stay purely registered: upstream valid depends on it.
    assign stall_out  = (state != DIV_IDLE);
    assign valid_out  = (state == DIV_DONE) && !stall_in && !reset && !flush;
    assign result_out = result_q;
    assign tag_out    = tag_q;

endmodule
